// File: rtl/cdc_rst_seq.sv
// cdc_rst_seq: staged reset-release sequencer for a single clock domain.
// It holds all stage resets, then releases them one at a time in stage order.
// Optional feature macro: CDC_RST_SEQ_ACK_EN.
//   Defined: each stage waits for its stage_ready acknowledge, with a timeout.
//   Undefined: acks are always satisfied, and timeout_err/err_stage stay 0.
module cdc_rst_seq #(
  parameter int unsigned NUM_STAGES  = 3,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned STAGE_DELAY = 8,
  parameter int unsigned ACK_TIMEOUT = 1024,
  localparam int unsigned SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sw_rst_req,
  input  logic [NUM_STAGES-1:0] stage_ready,
  output logic [NUM_STAGES-1:0] stage_rst,
  output logic                  done,
  output logic                  timeout_err,
  output logic [SW-1:0]         err_stage
);

  localparam int unsigned MAX_CNT = (HOLD_CYCLES > ACK_TIMEOUT) ? HOLD_CYCLES : ACK_TIMEOUT;
  localparam int unsigned CW      = $clog2(MAX_CNT + 1);
  localparam int unsigned LAST    = NUM_STAGES - 1;

  // Reject out-of-range configurations at elaboration.
  if (NUM_STAGES < 1 || NUM_STAGES > 16) begin : g_bad_num_stages
    $error("cdc_rst_seq: NUM_STAGES must be in 1..16");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("cdc_rst_seq: HOLD_CYCLES must be >= 1");
  end
  if (STAGE_DELAY < 1) begin : g_bad_delay
    $error("cdc_rst_seq: STAGE_DELAY must be >= 1");
  end
  if (ACK_TIMEOUT <= STAGE_DELAY) begin : g_bad_timeout
    $error("cdc_rst_seq: ACK_TIMEOUT must exceed STAGE_DELAY");
  end

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [SW-1:0]           stg_q, stg_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [NUM_STAGES-1:0]   stage_rst_d;
  logic                    done_d;
  logic                    timeout_err_d;
  logic [SW-1:0]           err_stage_d;
  logic [31:0]             cnt_p1;
  logic                    ack_c;
  logic                    tmo_c;

  // Edges elapsed since the current stage was released (counter restarts at 0).
  assign cnt_p1 = 32'(cnt_q) + 32'd1;

`ifdef CDC_RST_SEQ_ACK_EN
  // Select the acknowledge of the stage currently being waited on; flag a timeout when it is late.
  always_comb begin
    ack_c = 1'b0;
    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
      if (SW'(i) == stg_q) ack_c = stage_ready[i];
    end
    tmo_c = (cnt_p1 >= ACK_TIMEOUT) && !ack_c;
  end
`else
  logic unused_stage_ready;
  assign unused_stage_ready = ^stage_ready;
  // Without the ack feature, every stage is acknowledged immediately and never times out.
  always_comb begin
    ack_c = 1'b1;
    tmo_c = 1'b0;
  end
`endif

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_HOLD;
      stg_q       <= '0;
      cnt_q       <= '0;
      stage_rst   <= '1;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      err_stage   <= '0;
    end else begin
      state_q     <= state_d;
      stg_q       <= stg_d;
      cnt_q       <= cnt_d;
      stage_rst   <= stage_rst_d;
      done        <= done_d;
      timeout_err <= timeout_err_d;
      err_stage   <= err_stage_d;
    end
  end

  // Next-state logic: hold, release stages in order, then saturate in DONE.
  always_comb begin
    state_d       = state_q;
    stg_d         = stg_q;
    cnt_d         = cnt_q;
    stage_rst_d   = stage_rst;
    done_d        = done;
    timeout_err_d = timeout_err;
    err_stage_d   = err_stage;

    if (sw_rst_req) begin
      // A software request restarts the sequence but keeps the sticky error state.
      state_d     = S_HOLD;
      stg_d       = '0;
      cnt_d       = '0;
      stage_rst_d = '1;
      done_d      = 1'b0;
    end else begin
      case (state_q)
        S_HOLD: begin
          if (cnt_p1 >= HOLD_CYCLES) begin
            state_d        = S_WAIT;
            stg_d          = '0;
            cnt_d          = '0;
            stage_rst_d[0] = 1'b0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_WAIT: begin
          if (((cnt_p1 >= STAGE_DELAY) && ack_c) || tmo_c) begin
            // A timeout lets the sequence proceed as if the ack had arrived.
            if (tmo_c && !timeout_err) begin
              timeout_err_d = 1'b1;
              err_stage_d   = stg_q;
            end
            cnt_d = '0;
            if (stg_q == SW'(LAST)) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              stg_d = stg_q + SW'(1);
              for (int unsigned i = 0; i < NUM_STAGES; i++) begin
                if (SW'(i) == stg_d) stage_rst_d[i] = 1'b0;
              end
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_DONE: begin
          if (cnt_q != {CW{1'b1}}) cnt_d = cnt_q + CW'(1);
        end
        default: begin
          state_d = S_HOLD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cdc_rst_seq.sv
// Testbench for cdc_rst_seq: table-driven vectors plus hand-written corner sequences.
// The tables are selected by CDC_RST_SEQ_ACK_EN to match the build of the design.
module tb_cdc_rst_seq;

  logic       clk;
  logic       rst;
  logic       sw_rst_req;
  logic [2:0] stage_ready;
  logic [2:0] stage_rst;
  logic       done;
  logic       timeout_err;
  logic [1:0] err_stage;

  logic       rnd_ready;
  int         n_vec;
  int         n_err;

  typedef struct {
    logic       rst;
    logic       sw;
    logic [2:0] ready;
    logic       rnd;
    int         ncyc;
    logic [2:0] exp_rst;
    logic       exp_done;
    logic       exp_terr;
    logic [1:0] exp_es;
  } vec_t;

  vec_t vecs[$];

  cdc_rst_seq #(
    .NUM_STAGES (3),
    .HOLD_CYCLES(16),
    .STAGE_DELAY(8),
    .ACK_TIMEOUT(64)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sw_rst_req (sw_rst_req),
    .stage_ready(stage_ready),
    .stage_rst  (stage_rst),
    .done       (done),
    .timeout_err(timeout_err),
    .err_stage  (err_stage)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(input logic r, input logic s, input logic [2:0] rd,
                              input logic rn, input int n, input logic [2:0] er,
                              input logic ed, input logic et, input logic [1:0] ee);
    vec_t v;
    v.rst = r; v.sw = s; v.ready = rd; v.rnd = rn; v.ncyc = n;
    v.exp_rst = er; v.exp_done = ed; v.exp_terr = et; v.exp_es = ee;
    vecs.push_back(v);
  endfunction

  // Advance n clock edges, leaving inputs stable across each edge and sampling #1 after it.
  task automatic step(input int n);
    for (int j = 0; j < n; j++) begin
      @(posedge clk);
      #1;
      if (rnd_ready) stage_ready = 3'($urandom);
    end
  endtask

  task automatic check(input string name, input logic [2:0] er, input logic ed,
                       input logic et, input logic [1:0] ee);
    logic [6:0] act;
    logic [6:0] exp;
    act = {stage_rst, done, timeout_err, err_stage};
    exp = {er, ed, et, ee};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got {stage_rst,done,terr,err_stage}=%b, expected %b (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  initial begin
    n_vec       = 0;
    n_err       = 0;
    rnd_ready   = 1'b0;
    rst         = 1'b1;
    sw_rst_req  = 1'b0;
    stage_ready = 3'b111;

`ifdef CDC_RST_SEQ_ACK_EN
    // Stage 1 ack first high at edge 50.
    add(1,0,3'b101,0, 3, 3'b111,0,0,2'd0);
    add(0,0,3'b101,0,16, 3'b110,0,0,2'd0);
    add(0,0,3'b101,0, 8, 3'b100,0,0,2'd0);
    add(0,0,3'b101,0,25, 3'b100,0,0,2'd0);
    add(0,0,3'b111,0, 1, 3'b000,0,0,2'd0);
    add(0,0,3'b111,0, 7, 3'b000,0,0,2'd0);
    add(0,0,3'b111,0, 1, 3'b000,1,0,2'd0);
    // Stage 0 ack held low: timeout at edge 80.
    add(1,0,3'b110,0, 3, 3'b111,0,0,2'd0);
    add(0,0,3'b110,0,16, 3'b110,0,0,2'd0);
    add(0,0,3'b110,0,63, 3'b110,0,0,2'd0);
    add(0,0,3'b110,0, 1, 3'b100,0,1,2'd0);
    add(0,0,3'b110,0, 8, 3'b000,0,1,2'd0);
    add(0,0,3'b110,0, 8, 3'b000,1,1,2'd0);
    add(0,0,3'b110,0, 3, 3'b000,1,1,2'd0);
    // Software request at edge 100 keeps the sticky error.
    add(0,1,3'b110,0, 1, 3'b111,0,1,2'd0);
    add(0,0,3'b110,0,15, 3'b111,0,1,2'd0);
    add(0,0,3'b110,0, 1, 3'b110,0,1,2'd0);
    add(0,0,3'b110,0, 3, 3'b110,0,1,2'd0);
    // rst at edge 120 clears the error; release timing then repeats from that edge.
    add(1,0,3'b111,0, 1, 3'b111,0,0,2'd0);
    add(0,0,3'b111,0,16, 3'b110,0,0,2'd0);
    add(0,0,3'b111,0, 8, 3'b100,0,0,2'd0);
    add(0,0,3'b111,0, 8, 3'b000,0,0,2'd0);
    add(0,0,3'b111,0, 8, 3'b000,1,0,2'd0);
    // Last-stage timeout reports err_stage=2.
    add(1,0,3'b011,0, 1, 3'b111,0,0,2'd0);
    add(0,0,3'b011,0,16, 3'b110,0,0,2'd0);
    add(0,0,3'b011,0, 8, 3'b100,0,0,2'd0);
    add(0,0,3'b011,0, 8, 3'b000,0,0,2'd0);
    add(0,0,3'b011,0,63, 3'b000,0,0,2'd0);
    add(0,0,3'b011,0, 1, 3'b000,1,1,2'd2);
    // Two timeouts: err_stage keeps the first (stage 0).
    add(1,0,3'b010,0, 1, 3'b111,0,0,2'd0);
    add(0,0,3'b010,0,16, 3'b110,0,0,2'd0);
    add(0,0,3'b010,0,64, 3'b100,0,1,2'd0);
    add(0,0,3'b010,0, 8, 3'b000,0,1,2'd0);
    add(0,0,3'b010,0,63, 3'b000,0,1,2'd0);
    add(0,0,3'b010,0, 1, 3'b000,1,1,2'd0);
`else
    // Nominal release timing with acks all high.
    add(1,0,3'b111,0, 3, 3'b111,0,0,2'd0);
    add(0,0,3'b111,0,15, 3'b111,0,0,2'd0);
    add(0,0,3'b111,0, 1, 3'b110,0,0,2'd0);
    add(0,0,3'b111,0, 7, 3'b110,0,0,2'd0);
    add(0,0,3'b111,0, 1, 3'b100,0,0,2'd0);
    add(0,0,3'b111,0, 7, 3'b100,0,0,2'd0);
    add(0,0,3'b111,0, 1, 3'b000,0,0,2'd0);
    add(0,0,3'b111,0, 7, 3'b000,0,0,2'd0);
    add(0,0,3'b111,0, 1, 3'b000,1,0,2'd0);
    add(0,0,3'b111,0,20, 3'b000,1,0,2'd0);
    // Software request pulse restarts the hold.
    add(0,1,3'b111,0, 1, 3'b111,0,0,2'd0);
    add(0,0,3'b111,0,15, 3'b111,0,0,2'd0);
    add(0,0,3'b111,0, 1, 3'b110,0,0,2'd0);
    add(0,0,3'b111,0, 5, 3'b110,0,0,2'd0);
    // rst pulse mid-sequence.
    add(1,0,3'b111,0, 1, 3'b111,0,0,2'd0);
    add(0,0,3'b111,0,16, 3'b110,0,0,2'd0);
    add(0,0,3'b111,0, 8, 3'b100,0,0,2'd0);
    add(0,0,3'b111,0, 8, 3'b000,0,0,2'd0);
    add(0,0,3'b111,0, 8, 3'b000,1,0,2'd0);
    // Random stage_ready is ignored.
    add(1,0,3'b000,1, 2, 3'b111,0,0,2'd0);
    add(0,0,3'b000,1,16, 3'b110,0,0,2'd0);
    add(0,0,3'b000,1, 8, 3'b100,0,0,2'd0);
    add(0,0,3'b000,1, 8, 3'b000,0,0,2'd0);
    add(0,0,3'b000,1, 7, 3'b000,0,0,2'd0);
    add(0,0,3'b000,1, 1, 3'b000,1,0,2'd0);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      rst         = vecs[i].rst;
      sw_rst_req  = vecs[i].sw;
      stage_ready = vecs[i].ready;
      rnd_ready   = vecs[i].rnd;
      step(vecs[i].ncyc);
      check($sformatf("vec%0d", i), vecs[i].exp_rst, vecs[i].exp_done,
            vecs[i].exp_terr, vecs[i].exp_es);
    end
    rnd_ready = 1'b0;

`ifdef CDC_RST_SEQ_ACK_EN
    // rst and sw_rst_req together: the error state clears.
    rst = 1'b1; sw_rst_req = 1'b1;
    step(1);
    check("rst_and_sw", 3'b111, 1'b0, 1'b0, 2'd0);
    sw_rst_req = 1'b0;
`endif

    // Held reset freezes the counter: release comes 16 edges after the last request.
    rst = 1'b1; sw_rst_req = 1'b1; stage_ready = 3'b111;
    step(1);
    rst = 1'b0;
    step(30);
    check("sw_held", 3'b111, 1'b0, 1'b0, 2'd0);
    sw_rst_req = 1'b0;
    step(15);
    check("sw_hold_minus1", 3'b111, 1'b0, 1'b0, 2'd0);
    step(1);
    check("sw_hold_release", 3'b110, 1'b0, 1'b0, 2'd0);

    // Per-edge sweep of the release timeline against edge-number thresholds.
    rst = 1'b1; stage_ready = 3'b111;
`ifndef CDC_RST_SEQ_ACK_EN
    rnd_ready = 1'b1;
`endif
    step(1);
    rst = 1'b0;
    for (int n = 1; n <= 45; n++) begin
      step(1);
      check($sformatf("sweep_edge%0d", n), {(n < 32), (n < 24), (n < 16)}, (n >= 40), 1'b0, 2'd0);
    end
    rnd_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
